// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit sequencer driving the TX output mux line select
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic [1:0]            mux_select,
    output logic                  busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic                  par_en_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (DATA_VALID) begin
                        shift_q  <= P_DATA;
                        par_en_q <= PAR_EN;
                        par_bit  <= (^P_DATA) ^ PAR_TYP;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    bit_cnt <= '0;
                    state   <= S_DATA;
                end
                S_DATA: begin
                    shift_q <= shift_q >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        state   <= par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    stop_cnt <= 1'b0;
                    state    <= S_STOP;
                end
                S_STOP: begin
                    // stop_cnt is zero on every entry into STOP
                    if (stop_cnt == STOP_LAST) begin
                        stop_cnt <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mux_select = 2'b01;
        case (state)
            S_START:  mux_select = 2'b00;
            S_DATA:   mux_select = 2'b10;
            S_PARITY: mux_select = 2'b11;
            default:  mux_select = 2'b01;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign ser_data = shift_q[0];

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       dv1 = 1'b0;
    logic       dv2 = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;

    logic       ser1, par1, busy1, ser2, par2, busy2;
    logic [1:0] mux1, mux2;

    int n_assert = 0;
    int n_fail   = 0;
    int sel      = 0;

    logic       ser_o, par_o, busy_o;
    logic [1:0] mux_o;

    assign ser_o  = sel ? ser2  : ser1;
    assign par_o  = sel ? par2  : par1;
    assign busy_o = sel ? busy2 : busy1;
    assign mux_o  = sel ? mux2  : mux1;

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .P_DATA(p_data), .DATA_VALID(dv1),
        .PAR_EN(par_en), .PAR_TYP(par_typ),
        .ser_data(ser1), .par_bit(par1), .mux_select(mux1), .busy(busy1)
    );

    uart_tx_ctrl #(.DATA_WIDTH(7), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .P_DATA(p_data[6:0]), .DATA_VALID(dv2),
        .PAR_EN(par_en), .PAR_TYP(par_typ),
        .ser_data(ser2), .par_bit(par2), .mux_select(mux2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: pulse DATA_VALID; 1: also disturb inputs mid-frame;
    // 2: keep DATA_VALID high and put nd on P_DATA mid-frame
    task automatic frame(input int s, input logic [7:0] d, input logic pe, input logic pt,
                         input logic exp_par, input int w, input int stops,
                         input int mode, input logic [7:0] nd, input string tag);
        int cyc;
        logic [1:0] exp_mux;
        sel = s;
        p_data  = d;
        par_en  = pe;
        par_typ = pt;
        if (s == 0) dv1 = 1'b1; else dv2 = 1'b1;
        @(negedge clk);
        if (mode != 2) begin
            dv1 = 1'b0;
            dv2 = 1'b0;
        end
        cyc = 0;
        while (busy_o === 1'b1 && cyc < 40) begin
            if (cyc == 0)                 exp_mux = 2'b00;
            else if (cyc <= w)            exp_mux = 2'b10;
            else if (pe && cyc == w + 1)  exp_mux = 2'b11;
            else                          exp_mux = 2'b01;
            chk({tag, "_mux"}, {6'd0, mux_o}, {6'd0, exp_mux});
            if (exp_mux == 2'b10) chk({tag, "_ser"}, {7'd0, ser_o}, {7'd0, d[cyc-1]});
            if (exp_mux == 2'b11) chk({tag, "_par"}, {7'd0, par_o}, {7'd0, exp_par});
            if (mode == 1 && cyc == 3) begin
                p_data  = ~d;
                par_en  = ~pe;
                par_typ = ~pt;
            end
            if (mode == 2 && cyc == 2) p_data = nd;
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_len"}, 8'(cyc), 8'(1 + w + int'(pe) + stops));
        chk({tag, "_idle_mux"}, {6'd0, mux_o}, 8'h01);
        chk({tag, "_idle_busy"}, {7'd0, busy_o}, 8'h00);
        chk({tag, "_par_hold"}, {7'd0, par_o}, {7'd0, exp_par});
    endtask

    initial begin
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst1_mux", {6'd0, mux1}, 8'h01);
        chk("rst1_busy", {7'd0, busy1}, 8'h00);
        chk("rst1_ser", {7'd0, ser1}, 8'h00);
        chk("rst1_par", {7'd0, par1}, 8'h00);
        chk("rst2_mux", {6'd0, mux2}, 8'h01);
        chk("rst2_busy", {7'd0, busy2}, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_mux", {6'd0, mux1}, 8'h01);

        frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 8, 1, 0, 8'h00, "a5_even");
        frame(0, 8'hA5, 1'b1, 1'b1, 1'b1, 8, 1, 0, 8'h00, "a5_odd");
        frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 8, 1, 0, 8'h00, "a5_nopar");
        frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 8, 1, 1, 8'h00, "a5_disturb");

        // held DATA_VALID: second frame must start after exactly one idle cycle
        frame(0, 8'h3C, 1'b1, 1'b0, 1'b0, 8, 1, 2, 8'hC3, "b2b_3c");
        par_typ = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_restart_mux", {6'd0, mux1}, 8'h00);
        chk("b2b_restart_busy", {7'd0, busy1}, 8'h01);
        dv1 = 1'b0;
        cyc_drain();
        frame(0, 8'hC3, 1'b1, 1'b1, 1'b1, 8, 1, 0, 8'h00, "after_b2b");

        // reset in the middle of DATA
        sel = 0;
        p_data = 8'hFF;
        par_en = 1'b1;
        par_typ = 1'b1;
        dv1 = 1'b1;
        @(negedge clk);
        dv1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_mux", {6'd0, mux1}, 8'h02);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_mux", {6'd0, mux1}, 8'h01);
        chk("midrst_busy", {7'd0, busy1}, 8'h00);
        chk("midrst_ser", {7'd0, ser1}, 8'h00);
        chk("midrst_par", {7'd0, par1}, 8'h00);
        @(negedge clk);
        chk("midrst2_busy", {7'd0, busy1}, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        frame(0, 8'h96, 1'b1, 1'b0, 1'b0, 8, 1, 0, 8'h00, "post_rst");

        frame(1, 8'h55, 1'b1, 1'b1, 1'b1, 7, 2, 0, 8'h00, "w7_s2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Walk the remainder of the frame started by the held strobe, bounded.
    task automatic cyc_drain();
        int k;
        k = 0;
        @(negedge clk);
        while (busy1 === 1'b1 && k < 40) begin
            if (mux1 == 2'b10) chk("b2b_c3_ser", {7'd0, ser1}, {7'd0, p_data[k]});
            if (mux1 == 2'b11) chk("b2b_c3_par", {7'd0, par1}, 8'h01);
            if (mux1 == 2'b10) k++;
            @(negedge clk);
            if (mux1 != 2'b10 && k == 0) k = 0;
        end
        chk("b2b_c3_bits", 8'(k), 8'd8);
    endtask

endmodule
